// File: rtl/alien_formation.sv
// alien_formation: ROWS x COLS block of aliens that marches across the
// screen, steps down at the edges and loses members to the player bullet.
// Lives in the pixel-clock domain. Render and kill results are registered.
module alien_formation #(
    parameter int          ROWS      = 2,
    parameter int          COLS      = 4,
    parameter int          ALIEN_W   = 16,
    parameter int          ALIEN_H   = 16,
    parameter int          SPACING_X = 24,
    parameter int          SPACING_Y = 24,
    parameter int          START_X   = 100,
    parameter int          START_Y   = 100,
    parameter int          STEP_X    = 2,
    parameter int          STEP_DOWN = 8,
    parameter int          X_MIN     = 0,
    parameter int          X_MAX     = 639,
    parameter int          Y_LIMIT   = 400,
    parameter logic [7:0]  COLOR_R   = 8'hFF,
    parameter logic [7:0]  COLOR_G   = 8'h00,
    parameter logic [7:0]  COLOR_B   = 8'hFF,
    localparam int         N         = ROWS * COLS,
    localparam int         IDX_W     = (N > 1) ? $clog2(N) : 1
) (
    input  logic                    pixel_clk,
    input  logic                    rst,
    input  logic                    fsync,
    input  logic signed [11:0]      hpos,
    input  logic signed [11:0]      vpos,
    input  logic signed [11:0]      bullet_x,
    input  logic signed [11:0]      bullet_y,
    input  logic                    bullet_active,
    output logic [7:0]              pixel [0:2],
    output logic                    active,
    output logic [N-1:0]            alive_mask,
    output logic                    all_dead,
    output logic                    alien_hit,
    output logic [IDX_W-1:0]        hit_index,
    output logic [3:0]              wave,
    output logic                    invaded
);

    localparam int FORM_W = (COLS - 1) * SPACING_X + ALIEN_W;
    localparam int FORM_H = (ROWS - 1) * SPACING_Y + ALIEN_H;

    localparam logic signed [11:0] AW           = 12'(ALIEN_W);
    localparam logic signed [11:0] AH           = 12'(ALIEN_H);
    localparam logic signed [11:0] START_X12    = 12'(START_X);
    localparam logic signed [11:0] START_Y12    = 12'(START_Y);
    localparam logic signed [11:0] STEP_X12     = 12'(STEP_X);
    localparam logic signed [11:0] STEP_DOWN12  = 12'(STEP_DOWN);
    localparam logic signed [11:0] X_MIN12      = 12'(X_MIN);
    localparam logic signed [11:0] X_MAX12      = 12'(X_MAX);
    localparam logic signed [11:0] Y_LIMIT12    = 12'(Y_LIMIT);
    // Distance from origin to the rightmost pixel after a horizontal step
    localparam logic signed [11:0] RIGHT_REACH  = 12'(FORM_W - 1 + STEP_X);
    localparam logic signed [11:0] BOTTOM_REACH = 12'(FORM_H - 1);

    typedef enum logic [1:0] {
        StRight,
        StLeft,
        StFrozen
    } motion_e;

    motion_e            state;
    logic signed [11:0] ox;
    logic signed [11:0] oy;
    logic               armed;
    logic               fsync_q;

    logic               tick;
    logic               kill;
    logic               kill_found;
    logic [IDX_W-1:0]   kill_idx;
    logic               raster_cover;
    logic               right_blocked;
    logic               left_blocked;
    logic               invade;
    logic signed [11:0] oy_down;

    // True when point (px,py) lies inside alien idx for formation origin (org_x,org_y)
    function automatic logic covers(input int idx,
                                    input logic signed [11:0] px,
                                    input logic signed [11:0] py,
                                    input logic signed [11:0] org_x,
                                    input logic signed [11:0] org_y);
        logic signed [11:0] x0;
        logic signed [11:0] y0;
        x0 = org_x + 12'((idx % COLS) * SPACING_X);
        y0 = org_y + 12'((idx / COLS) * SPACING_Y);
        return (px >= x0) && (px < x0 + AW) && (py >= y0) && (py < y0 + AH);
    endfunction

    assign tick          = fsync & ~fsync_q;
    assign all_dead      = ~|alive_mask;
    assign right_blocked = (ox + RIGHT_REACH) > X_MAX12;
    assign left_blocked  = (ox - STEP_X12) < X_MIN12;
    assign oy_down       = oy + STEP_DOWN12;
    assign invade        = (oy_down + BOTTOM_REACH) >= Y_LIMIT12;
    assign kill          = (state != StFrozen) && bullet_active && armed && kill_found;

    // Bullet and raster hit tests against every alive alien; lowest index wins a kill
    always_comb begin
        kill_found   = 1'b0;
        kill_idx     = '0;
        raster_cover = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (alive_mask[i] && !kill_found && covers(i, bullet_x, bullet_y, ox, oy)) begin
                kill_found = 1'b1;
                kill_idx   = IDX_W'(i);
            end
            if (alive_mask[i] && covers(i, hpos, vpos, ox, oy)) begin
                raster_cover = 1'b1;
            end
        end
    end

    // Motion FSM, wave reload, kill bookkeeping and the bullet arming latch
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            state      <= StRight;
            ox         <= START_X12;
            oy         <= START_Y12;
            alive_mask <= '1;
            armed      <= 1'b1;
            alien_hit  <= 1'b0;
            hit_index  <= '0;
            wave       <= 4'd0;
            invaded    <= 1'b0;
        end else begin
            alien_hit <= kill;
            if (kill) begin
                alive_mask[kill_idx] <= 1'b0;
                hit_index            <= kill_idx;
                armed                <= 1'b0;
            end else if (!bullet_active) begin
                armed <= 1'b1;
            end

            if (tick && state != StFrozen) begin
                if (all_dead) begin
                    // New wave: a kill cannot coincide since nothing is alive
                    ox         <= START_X12;
                    oy         <= START_Y12;
                    state      <= StRight;
                    alive_mask <= '1;
                    wave       <= wave + 4'd1;
                end else begin
                    case (state)
                        StRight: begin
                            if (right_blocked) begin
                                oy <= oy_down;
                                if (invade) begin
                                    invaded <= 1'b1;
                                    state   <= StFrozen;
                                end else begin
                                    state <= StLeft;
                                end
                            end else begin
                                ox <= ox + STEP_X12;
                            end
                        end
                        StLeft: begin
                            if (left_blocked) begin
                                oy <= oy_down;
                                if (invade) begin
                                    invaded <= 1'b1;
                                    state   <= StFrozen;
                                end else begin
                                    state <= StRight;
                                end
                            end else begin
                                ox <= ox - STEP_X12;
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end
        end
    end

    // Frame-sync edge history and registered pixel output
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            fsync_q  <= 1'b0;
            active   <= 1'b0;
            pixel[0] <= 8'h00;
            pixel[1] <= 8'h00;
            pixel[2] <= 8'h00;
        end else begin
            fsync_q  <= fsync;
            active   <= raster_cover;
            pixel[0] <= raster_cover ? COLOR_R : 8'h00;
            pixel[1] <= raster_cover ? COLOR_G : 8'h00;
            pixel[2] <= raster_cover ? COLOR_B : 8'h00;
        end
    end

endmodule

// File: tb/tb_alien_formation.sv
// Bench for alien_formation: directed scenarios plus a randomized run against
// a behavioural model of the formation game rules.
module tb_alien_formation;

    localparam int ROWS = 2, COLS = 4, N = 8;
    localparam int AW = 16, AH = 16, SX = 24, SY = 24;
    localparam int START_X = 100, START_Y = 100, STEP_X = 2, STEP_DOWN = 8;
    localparam int X_MIN = 0, X_MAX = 199, Y_LIMIT = 150;
    localparam int FORM_W = (COLS - 1) * SX + AW;
    localparam int FORM_H = (ROWS - 1) * SY + AH;

    logic               pixel_clk = 1'b0;
    logic               rst = 1'b1;
    logic               fsync = 1'b0;
    logic signed [11:0] hpos = '0, vpos = '0, bullet_x = '0, bullet_y = '0;
    logic               bullet_active = 1'b0;
    logic [7:0]         pixel [0:2];
    logic               active, all_dead, alien_hit, invaded;
    logic [N-1:0]       alive_mask;
    logic [2:0]         hit_index;
    logic [3:0]         wave;

    always #5 pixel_clk = ~pixel_clk;

    alien_formation #(.X_MAX(X_MAX), .Y_LIMIT(Y_LIMIT)) dut (
        .pixel_clk(pixel_clk), .rst(rst), .fsync(fsync),
        .hpos(hpos), .vpos(vpos), .bullet_x(bullet_x), .bullet_y(bullet_y),
        .bullet_active(bullet_active), .pixel(pixel), .active(active),
        .alive_mask(alive_mask), .all_dead(all_dead), .alien_hit(alien_hit),
        .hit_index(hit_index), .wave(wave), .invaded(invaded)
    );

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model of the game
    int m_ox, m_oy, m_wave;
    bit m_right, m_frozen, m_invaded, m_armed, m_fs_prev;
    bit m_alive [N];
    bit exp_active, exp_hit;
    int exp_idx = 0;

    function automatic bit m_inside(int i, int px, int py);
        int left, top;
        left = m_ox + (i % COLS) * SX;
        top  = m_oy + (i / COLS) * SY;
        return px >= left && px < left + AW && py >= top && py < top + AH;
    endfunction

    function automatic bit [N-1:0] m_mask();
        bit [N-1:0] m;
        m = '0;
        for (int i = 0; i < N; i++) m[i] = m_alive[i];
        return m;
    endfunction

    task automatic model_reset();
        m_ox = START_X; m_oy = START_Y; m_wave = 0;
        m_right = 1; m_frozen = 0; m_invaded = 0; m_armed = 1; m_fs_prev = 0;
        for (int i = 0; i < N; i++) m_alive[i] = 1;
    endtask

    task automatic model_step_down();
        m_oy += STEP_DOWN;
        m_right = !m_right;
        if (m_oy + FORM_H - 1 >= Y_LIMIT) begin
            m_invaded = 1;
            m_frozen = 1;
        end
    endtask

    task automatic model_update();
        bit tick, dead, hit;
        int idx, bx, by, hx, hy;
        if (rst) begin
            model_reset();
            exp_active = 0;
            exp_hit = 0;
            return;
        end
        bx = int'(bullet_x); by = int'(bullet_y);
        hx = int'(hpos);     hy = int'(vpos);
        tick = fsync && !m_fs_prev;
        m_fs_prev = fsync;
        dead = (m_mask() == '0);
        exp_active = 0;
        for (int i = 0; i < N; i++) if (m_alive[i] && m_inside(i, hx, hy)) exp_active = 1;
        hit = 0; idx = 0;
        if (!m_frozen && bullet_active && m_armed)
            for (int i = 0; i < N; i++)
                if (!hit && m_alive[i] && m_inside(i, bx, by)) begin hit = 1; idx = i; end
        exp_hit = hit;
        if (hit) begin
            exp_idx = idx;
            m_alive[idx] = 0;
            m_armed = 0;
        end else if (!bullet_active) begin
            m_armed = 1;
        end
        if (tick && !m_frozen) begin
            if (dead) begin
                m_ox = START_X; m_oy = START_Y; m_right = 1;
                for (int i = 0; i < N; i++) m_alive[i] = 1;
                m_wave = (m_wave + 1) % 16;
            end else if (m_right) begin
                if (m_ox + FORM_W - 1 + STEP_X > X_MAX) model_step_down();
                else m_ox += STEP_X;
            end else begin
                if (m_ox - STEP_X < X_MIN) model_step_down();
                else m_ox -= STEP_X;
            end
        end
    endtask

    task automatic step();
        @(posedge pixel_clk);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        rst = 1; fsync = 0; bullet_active = 0; hpos = '0; vpos = '0;
        step(); step();
        rst = 0;
    endtask

    task automatic frame_tick();
        fsync = 1; step();
        fsync = 0; step();
    endtask

    task automatic probe(input int x, input int y, output bit act);
        hpos = 12'(x); vpos = 12'(y);
        step();
        act = active;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec += 7;
        if (alive_mask !== 8'hFF) begin n_err++; $display("FAIL reset_alive: got %h want ff", alive_mask); end
        if (pixel[0] !== 8'h00 || pixel[1] !== 8'h00 || pixel[2] !== 8'h00) begin
            n_err++; $display("FAIL reset_pixel: got %h/%h/%h want 00/00/00", pixel[0], pixel[1], pixel[2]);
        end
        if (active !== 1'b0) begin n_err++; $display("FAIL reset_active: got %b want 0", active); end
        if (alien_hit !== 1'b0) begin n_err++; $display("FAIL reset_hit: got %b want 0", alien_hit); end
        if (wave !== 4'd0) begin n_err++; $display("FAIL reset_wave: got %0d want 0", wave); end
        if (invaded !== 1'b0) begin n_err++; $display("FAIL reset_invaded: got %b want 0", invaded); end
        if (all_dead !== 1'b0) begin n_err++; $display("FAIL reset_all_dead: got %b want 0", all_dead); end
    endtask

    task automatic test_miss();
        bit a0, a1;
        do_reset();
        bullet_x = 12'sd10; bullet_y = 12'sd110; bullet_active = 1;
        for (int t = 0; t < 3; t++) frame_tick();
        n_vec += 2;
        if (alive_mask !== 8'hFF) begin n_err++; $display("FAIL miss_alive: got %h want ff", alive_mask); end
        if (alien_hit !== 1'b0) begin n_err++; $display("FAIL miss_hit: got %b want 0", alien_hit); end
        probe(106, 100, a0);
        probe(105, 100, a1);
        n_vec++;
        if (a0 !== 1'b1 || a1 !== 1'b0) begin
            n_err++; $display("FAIL miss_ox106: active at x106=%b x105=%b want 1 0", a0, a1);
        end
        bullet_active = 0;
    endtask

    task automatic test_kill_disarm();
        do_reset();
        bullet_x = 12'sd105; bullet_y = 12'sd105; bullet_active = 1;
        step();
        n_vec += 3;
        if (alien_hit !== 1'b1) begin n_err++; $display("FAIL kill0_hit: got %b want 1", alien_hit); end
        if (hit_index !== 3'd0) begin n_err++; $display("FAIL kill0_index: got %0d want 0", hit_index); end
        if (alive_mask !== 8'hFE) begin n_err++; $display("FAIL kill0_alive: got %h want fe", alive_mask); end
        bullet_x = 12'sd129; bullet_y = 12'sd129;
        step();
        n_vec += 2;
        if (alien_hit !== 1'b0) begin n_err++; $display("FAIL disarm_hit: got %b want 0", alien_hit); end
        if (alive_mask !== 8'hFE) begin n_err++; $display("FAIL disarm_alive: got %h want fe", alive_mask); end
        bullet_active = 0; step();
        bullet_active = 1; step();
        n_vec += 3;
        if (alien_hit !== 1'b1) begin n_err++; $display("FAIL rearm_hit: got %b want 1", alien_hit); end
        if (hit_index !== 3'd5) begin n_err++; $display("FAIL rearm_index: got %0d want 5", hit_index); end
        if (alive_mask !== 8'hDE) begin n_err++; $display("FAIL rearm_alive: got %h want de", alive_mask); end
        bullet_active = 0;
    endtask

    task automatic test_edge_bounce();
        bit a0, a1;
        do_reset();
        for (int t = 0; t < 6; t++) frame_tick();
        probe(112, 100, a0); probe(111, 100, a1);
        n_vec++;
        if (a0 !== 1'b1 || a1 !== 1'b0) begin n_err++; $display("FAIL edge_ox112: got %b%b want 10", a0, a1); end
        frame_tick();
        probe(112, 108, a0); probe(112, 107, a1);
        n_vec++;
        if (a0 !== 1'b1 || a1 !== 1'b0) begin n_err++; $display("FAIL edge_oy108: got %b%b want 10", a0, a1); end
        probe(111, 108, a1);
        n_vec++;
        if (a1 !== 1'b0) begin n_err++; $display("FAIL edge_ox_hold: got %b want 0", a1); end
        frame_tick();
        probe(110, 108, a0); probe(109, 108, a1);
        n_vec++;
        if (a0 !== 1'b1 || a1 !== 1'b0) begin n_err++; $display("FAIL edge_left110: got %b%b want 10", a0, a1); end
    endtask

    task automatic test_render();
        bit a;
        do_reset();
        probe(100, 100, a);
        n_vec += 2;
        if (a !== 1'b1) begin n_err++; $display("FAIL render_on: got %b want 1", a); end
        if (pixel[0] !== 8'hFF || pixel[1] !== 8'h00 || pixel[2] !== 8'hFF) begin
            n_err++; $display("FAIL render_color: got %h/%h/%h want ff/00/ff", pixel[0], pixel[1], pixel[2]);
        end
        hpos = 12'sd0; #2;
        n_vec++;
        if (active !== 1'b1) begin n_err++; $display("FAIL render_latency: got %b want 1", active); end
        probe(116, 100, a);
        n_vec += 2;
        if (a !== 1'b0) begin n_err++; $display("FAIL render_gap: got %b want 0", a); end
        if (pixel[0] !== 8'h00) begin n_err++; $display("FAIL render_gap_pixel: got %h want 00", pixel[0]); end
        bullet_x = 12'sd100; bullet_y = 12'sd100; bullet_active = 1; step();
        bullet_active = 0;
        probe(100, 100, a);
        n_vec++;
        if (a !== 1'b0) begin n_err++; $display("FAIL render_dead: got %b want 0", a); end
    endtask

    task automatic test_wave_invasion();
        bit a0, a1;
        int hits, ticks;
        do_reset();
        hits = 0;
        for (int i = 0; i < N; i++) begin
            bullet_x = 12'(START_X + (i % COLS) * SX + 4);
            bullet_y = 12'(START_Y + (i / COLS) * SY + 4);
            bullet_active = 1; step();
            if (alien_hit === 1'b1) hits++;
            bullet_active = 0; step();
        end
        n_vec += 3;
        if (hits != N) begin n_err++; $display("FAIL killall_hits: got %0d want 8", hits); end
        if (alive_mask !== 8'h00) begin n_err++; $display("FAIL killall_alive: got %h want 00", alive_mask); end
        if (all_dead !== 1'b1) begin n_err++; $display("FAIL killall_dead: got %b want 1", all_dead); end
        frame_tick();
        n_vec += 2;
        if (alive_mask !== 8'hFF) begin n_err++; $display("FAIL wave_alive: got %h want ff", alive_mask); end
        if (wave !== 4'd1) begin n_err++; $display("FAIL wave_count: got %0d want 1", wave); end
        probe(100, 100, a0); probe(99, 100, a1);
        n_vec++;
        if (a0 !== 1'b1 || a1 !== 1'b0) begin n_err++; $display("FAIL wave_origin: got %b%b want 10", a0, a1); end
        // 7 ticks to the right edge, 56 back to x=0, then the invading step-down
        ticks = 0;
        for (int t = 1; t <= 100; t++) begin
            frame_tick();
            ticks = t;
            if (invaded === 1'b1) break;
        end
        n_vec += 2;
        if (invaded !== 1'b1) begin n_err++; $display("FAIL invade_flag: got %b want 1", invaded); end
        if (ticks != 64) begin n_err++; $display("FAIL invade_ticks: got %0d want 64", ticks); end
        frame_tick(); frame_tick();
        probe(0, 116, a0); probe(0, 115, a1);
        n_vec++;
        if (a0 !== 1'b1 || a1 !== 1'b0) begin n_err++; $display("FAIL frozen_pos: got %b%b want 10", a0, a1); end
        bullet_x = 12'sd4; bullet_y = 12'sd120; bullet_active = 1; step();
        n_vec += 2;
        if (alien_hit !== 1'b0) begin n_err++; $display("FAIL frozen_hit: got %b want 0", alien_hit); end
        if (alive_mask !== 8'hFF) begin n_err++; $display("FAIL frozen_alive: got %h want ff", alive_mask); end
        bullet_active = 0;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 3) == 0) fsync = ~fsync;
            bullet_active = ($urandom_range(0, 9) < 7);
            bullet_x = 12'(m_ox - 8 + int'($urandom_range(0, FORM_W + 16)));
            bullet_y = 12'(m_oy - 8 + int'($urandom_range(0, FORM_H + 16)));
            hpos = 12'(m_ox - 8 + int'($urandom_range(0, FORM_W + 16)));
            vpos = 12'(m_oy - 8 + int'($urandom_range(0, FORM_H + 16)));
            step();
            n_vec += 7;
            if (alive_mask !== m_mask()) begin
                n_err++; $display("FAIL rand_alive c=%0d: got %h want %h", c, alive_mask, m_mask());
            end
            if (all_dead !== (m_mask() == '0)) begin
                n_err++; $display("FAIL rand_all_dead c=%0d: got %b", c, all_dead);
            end
            if (alien_hit !== exp_hit) begin
                n_err++; $display("FAIL rand_hit c=%0d: got %b want %b", c, alien_hit, exp_hit);
            end
            if (exp_hit && hit_index !== 3'(exp_idx)) begin
                n_err++; $display("FAIL rand_index c=%0d: got %0d want %0d", c, hit_index, exp_idx);
            end
            if (active !== exp_active) begin
                n_err++; $display("FAIL rand_active c=%0d: got %b want %b", c, active, exp_active);
            end
            if (pixel[0] !== (exp_active ? 8'hFF : 8'h00) || pixel[1] !== 8'h00 ||
                pixel[2] !== (exp_active ? 8'hFF : 8'h00)) begin
                n_err++; $display("FAIL rand_pixel c=%0d: got %h/%h/%h active_exp %b",
                                  c, pixel[0], pixel[1], pixel[2], exp_active);
            end
            if (wave !== 4'(m_wave) || invaded !== m_invaded) begin
                n_err++; $display("FAIL rand_wave_inv c=%0d: got %0d/%b want %0d/%b",
                                  c, wave, invaded, m_wave, m_invaded);
            end
        end
        rst = 0;
        bullet_active = 0;
    endtask

    initial begin
        model_reset();
        exp_active = 0;
        exp_hit = 0;
        test_reset();
        test_miss();
        test_kill_disarm();
        test_edge_bounce();
        test_render();
        test_wave_invasion();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alien_formation.md
# alien_formation

Parametrised ROWS×COLS grid of aliens moving as one formation. Marches horizontally once per frame, steps down and reverses at the screen edges, and removes individual aliens when hit by the player bullet (at most one kill per bullet). Starts a new wave when all aliens are dead. Sits in the pixel-clock game domain and feeds the pixel compositor alongside the ship and bullet blocks.

## Interface
- ROWS, 2, formation rows
- COLS, 4, formation columns; alien index = row*COLS + col
- ALIEN_W / ALIEN_H, 16 / 16, alien box size in pixels
- SPACING_X / SPACING_Y, 24 / 24, pitch between alien origins
- START_X / START_Y, 100 / 100, formation origin at reset and at each new wave
- STEP_X, 2, horizontal move per frame
- STEP_DOWN, 8, vertical move at an edge
- X_MIN / X_MAX, 0 / 639, inclusive horizontal play limits
- Y_LIMIT, 400, invasion line
- COLOR_R / COLOR_G / COLOR_B, 8'hFF / 8'h00 / 8'hFF, alien colour

Ports:
- pixel_clk  in  1  clock; all logic on its rising edge
- rst  in  1  synchronous, active-high reset
- fsync  in  1  frame sync; a frame tick is fsync & ~fsync_q
- hpos, vpos  in  12 signed  current raster position
- bullet_x, bullet_y  in  12 signed  bullet point position
- bullet_active  in  1  bullet in flight
- pixel[0:2]  out  8 each  R,G,B
- active  out  1  an alive alien covers the raster position
- alive_mask  out  ROWS*COLS  bit i = alien i alive
- all_dead  out  1  alive_mask == 0
- alien_hit  out  1  one-cycle kill pulse
- hit_index  out  $clog2(ROWS*COLS)  index of the killed alien; valid when alien_hit
- wave  out  4  wave counter, wraps 15→0
- invaded  out  1  sticky; formation reached Y_LIMIT

## Operation
- Geometry: alien i spans x ∈ [ox+col*SPACING_X, +ALIEN_W), y ∈ [oy+row*SPACING_Y, +ALIEN_H). FORM_W = (COLS-1)*SPACING_X+ALIEN_W; FORM_H = (ROWS-1)*SPACING_Y+ALIEN_H.
- All arithmetic is signed 12-bit. Parameters keep positions within ±2047; no wrap handling.
- Motion FSM states: RIGHT, LEFT, FROZEN. Moves are evaluated on the frame tick only:
  - RIGHT: if ox+FORM_W-1+STEP_X > X_MAX, then oy += STEP_DOWN, go to LEFT, ox unchanged. Otherwise ox += STEP_X.
  - LEFT: if ox-STEP_X < X_MIN, then oy += STEP_DOWN, go to RIGHT. Otherwise ox -= STEP_X.
  - After any step-down, if oy+FORM_H-1 ≥ Y_LIMIT: set invaded, go to FROZEN.
  - FROZEN: no motion and no kills. Only rst exits it.
- Wave: on a frame tick with all_dead=1 (not FROZEN), reload ox=START_X, oy=START_Y, state RIGHT, alive_mask all ones, and wave+1. No motion on that tick.
- Collision:
  - Every cycle, with bullet_active=1 and armed=1, test the bullet point against every alive alien box.
  - The lowest matching index is killed: its bit clears, alien_hit=1 and hit_index=i, all registered together.
  - armed clears on the kill and re-arms after any cycle with bullet_active=0.
- Render: active = raster inside any alive alien box. pixel = COLOR when active, else 0.

## Timing
- Reset values:
  - ox=START_X, oy=START_Y, state RIGHT, alive_mask all ones, armed=1.
  - pixel=0, active=0, alien_hit=0, hit_index=0, wave=0, invaded=0, all_dead=0.
- Render latency is 1 cycle: pixel/active at cycle n+1 reflect hpos/vpos at cycle n.
- Kill latency is 1 cycle from bullet sample to alive_mask/alien_hit. Collision uses pre-tick ox/oy.
- A frame tick moves the formation in the following cycle. Holding fsync high gives exactly one tick.
- Frame tick and kill in the same cycle: both apply.
- Last alien killed on a tick: the reload waits for the next tick.
- Simultaneous hits: only the lowest index dies; the others survive (armed now 0).
- rst mid-operation: full reload to reset values the following cycle, regardless of FSM state.

## Test plan
- Reset: rst high 2 cycles → alive_mask=8'hFF, pixel=0/0/0, active=0, alien_hit=0, wave=0, invaded=0.
- Miss: 3 frame ticks, bullet (10,110) active → alive_mask=8'hFF, no alien_hit, ox=106.
- Single kill and disarm:
  - From reset, bullet (105,105) → next cycle alien_hit=1, hit_index=0, alive_mask=8'hFE.
  - Move to (129,129) still active → no hit.
  - Drop bullet_active 1 cycle, reassert → hit_index=5, alive_mask=8'hDE.
- Edge bounce with X_MAX=199:
  - Ticks 1–6 → ox=112.
  - Tick 7 → oy=108, ox=112, LEFT.
  - Tick 8 → ox=110.
- Render: hpos/vpos (100,100) → next cycle active=1, pixel=FF/00/FF. (116,100) → active=0. Kill alien 0, then (100,100) → active=0.
- Wave/invasion:
  - Kill all 8 → all_dead=1. Next tick → alive_mask=8'hFF, ox=100, oy=100, wave=1.
  - With Y_LIMIT=150 and X_MAX=199, the second step-down (oy=116, bottom edge 155) → invaded=1, motion and kills frozen.
